instr_issuer: RTL and testbench

Program sequencer that drives the 23-bit instruction `code` into the processor control FSM. It holds a small instruction buffer and walks it from address 0. It presents each instruction stable for exactly its execution length, then returns `code` to zero so the controller goes back to idle. It sits between the testbench/program loader and the controller, and reads the controller's `current_state` back as a handshake.

---
 rtl/instr_issuer.sv | 171 +++++++++++++++++
 tb/tb_instr_issuer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issuer.sv
// Program sequencer: walks a DEPTH-word instruction buffer, holds each word on `code` for its latency.
// Latency: start -> first code_valid in 2 cycles; each instruction takes L+2 cycles with no stall.
// Backpressure: GAP stalls while ctrl_state != 0 (and, with SINGLE_STEP_EN defined, until step=1).
module instr_issuer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [22:0]   prog_wdata,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic [4:0]    ctrl_state,
`ifdef SINGLE_STEP_EN
    input  logic          step,
`endif
    output logic [22:0]   code,
    output logic          code_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [22:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [22:0]   code_q, code_d;
    logic          vld_q, vld_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [22:0]   word;
    logic [3:0]    func;
    logic          last;
    logic          advance;

    assign busy = (state_q == S_FETCH) || (state_q == S_HOLD) || (state_q == S_GAP);

    // Buffer has no reset so a program survives resetn
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    assign word = mem[pc_q];
    assign func = word[22:19];
    assign last = (({1'b0, pc_q} + (AW+1)'(1)) == len_q);

`ifdef SINGLE_STEP_EN
    assign advance = (ctrl_state == 5'd0) && step;
`else
    assign advance = (ctrl_state == 5'd0);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        code_d  = code_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    pc_d  = '0;
                    if (prog_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                case (func)
                    4'h0: begin
                        if (last) state_d = S_DONE;
                        else      pc_d    = pc_q + AW'(1);
                    end
                    4'h1, 4'h2: begin
                        code_d  = word;
                        vld_d   = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = S_HOLD;
                    end
                    4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                        code_d  = word;
                        vld_d   = 1'b1;
                        cnt_d   = 2'd2;
                        state_d = S_HOLD;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_HOLD: begin
                // cnt counts remaining HOLD cycles after this one
                if (cnt_q == 2'd0) begin
                    code_d  = '0;
                    vld_d   = 1'b0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_GAP: begin
                if (advance) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            code_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign code       = vld_q ? code_q : 23'd0;
    assign code_valid = vld_q;
    assign pc         = pc_q;
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: per-cycle output logs after each start, checked against hand-derived cycles.
module tb_instr_issuer;

    localparam int AW = 4;
    localparam int NC = 40;

    logic          clk;
    logic          resetn;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [22:0]   prog_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    logic [4:0]    ctrl_state;
    logic [22:0]   code;
    logic          code_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;

    logic [22:0]   code_log [NC];
    logic          vld_log  [NC];
    logic          busy_log [NC];
    logic          done_log [NC];
    logic          err_log  [NC];
    logic [AW-1:0] pc_log   [NC];

    instr_issuer #(.DEPTH(16), .AW(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_len   (prog_len),
        .start      (start),
        .ctrl_state (ctrl_state),
`ifdef SINGLE_STEP_EN
        .step       (1'b1),
`endif
        .code       (code),
        .code_valid (code_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int addr, input logic [22:0] data);
        prog_we    = 1'b1;
        prog_addr  = AW'(addr);
        prog_wdata = data;
        tick();
        prog_we    = 1'b0;
    endtask

    // Cycle 0 is the start cycle; ctrl_state=3 during cycles st_lo..st_hi; a write to mem[1] is attempted in cycle wr_c
    task automatic run(input int ncyc, input int st_lo, input int st_hi, input int wr_c);
        start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            code_log[c] = code;
            vld_log[c]  = code_valid;
            busy_log[c] = busy;
            done_log[c] = done;
            err_log[c]  = err;
            pc_log[c]   = pc;
            ctrl_state  = (c >= st_lo && c <= st_hi) ? 5'd3 : 5'd0;
            prog_we     = (c == wr_c);
            prog_addr   = AW'(1);
            prog_wdata  = 23'h7fffff;
            tick();
            start       = 1'b0;
        end
        prog_we    = 1'b0;
        ctrl_state = 5'd0;
    endtask

    function automatic int first_done(input int ncyc);
        for (int c = 0; c < ncyc; c++) if (done_log[c]) return c;
        return -1;
    endfunction

    function automatic int vld_count(input int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) if (vld_log[c]) n++;
        return n;
    endfunction

    function automatic int busy_count(input int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) if (busy_log[c]) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        resetn     = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        prog_len   = '0;
        start      = 1'b0;
        ctrl_state = 5'd0;
        tick();
        tick();
        chk("rst_code",  32'(code), 32'h0);
        chk("rst_vld",   32'(code_valid), 32'h0);
        chk("rst_pc",    32'(pc), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_err",   32'(err), 32'h0);
        resetn = 1'b1;
        tick();

        // load + add; write to mem[1] while busy must be dropped
        prog(0, 23'h090005);
        prog(1, 23'h194000);
        prog_len = 5'd2;
        run(12, -1, -1, 2);
        chk("t1_busy0",  32'(busy_log[0]), 32'h0);
        chk("t1_busy1",  32'(busy_log[1]), 32'h1);
        chk("t1_vld1",   32'(vld_log[1]), 32'h0);
        chk("t1_code2",  32'(code_log[2]), 32'h090005);
        chk("t1_vld2",   32'(vld_log[2]), 32'h1);
        chk("t1_code3",  32'(code_log[3]), 32'h0);
        chk("t1_vld4",   32'(vld_log[4]), 32'h0);
        chk("t1_code5",  32'(code_log[5]), 32'h194000);
        chk("t1_code7",  32'(code_log[7]), 32'h194000);
        chk("t1_vld8",   32'(vld_log[8]), 32'h0);
        chk("t1_done",   32'(first_done(12)), 32'd9);
        chk("t1_busy9",  32'(busy_log[9]), 32'h0);
        chk("t1_err9",   32'(err_log[9]), 32'h0);
        chk("t1_nvld",   32'(vld_count(12)), 32'd4);

        // zero-length program
        prog_len = 5'd0;
        run(6, -1, -1, -1);
        chk("t2_done",   32'(first_done(6)), 32'd1);
        chk("t2_nvld",   32'(vld_count(6)), 32'd0);
        chk("t2_nbusy",  32'(busy_count(6)), 32'd0);

        // nop then load
        prog(0, 23'h000000);
        prog(1, 23'h090007);
        prog_len = 5'd2;
        run(8, -1, -1, -1);
        chk("t3_vld2",   32'(vld_log[2]), 32'h0);
        chk("t3_pc2",    32'(pc_log[2]), 32'h1);
        chk("t3_code3",  32'(code_log[3]), 32'h090007);
        chk("t3_done",   32'(first_done(8)), 32'd5);

        // illegal opcode
        prog(0, 23'h090005);
        prog(1, 23'h780000);
        run(8, -1, -1, -1);
        chk("t4_nvld",   32'(vld_count(8)), 32'd1);
        chk("t4_done",   32'(first_done(8)), 32'd5);
        chk("t4_err5",   32'(err_log[5]), 32'h1);
        chk("t4_err7",   32'(err_log[7]), 32'h1);
        prog_len = 5'd1;
        run(8, -1, -1, -1);
        chk("t4_errclr", 32'(err_log[1]), 32'h0);
        chk("t4_done1",  32'(first_done(8)), 32'd4);

        // controller busy for 4 GAP cycles
        prog(1, 23'h194000);
        prog_len = 5'd2;
        run(16, 3, 6, -1);
        chk("t5_code3",  32'(code_log[3]), 32'h0);
        chk("t5_vld8",   32'(vld_log[8]), 32'h0);
        chk("t5_code9",  32'(code_log[9]), 32'h194000);
        chk("t5_vld11",  32'(vld_log[11]), 32'h1);
        chk("t5_vld12",  32'(vld_log[12]), 32'h0);
        chk("t5_done",   32'(first_done(16)), 32'd13);

        // reset mid-HOLD, then rerun from intact buffer
        run(6, -1, -1, -1);
        chk("t6_pre",    32'(code), 32'h194000);
        resetn = 1'b0;
        #1;
        chk("t6_code",   32'(code), 32'h0);
        chk("t6_vld",    32'(code_valid), 32'h0);
        chk("t6_busy",   32'(busy), 32'h0);
        chk("t6_pc",     32'(pc), 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        run(12, -1, -1, -1);
        chk("t6_code2",  32'(code_log[2]), 32'h090005);
        chk("t6_code5",  32'(code_log[5]), 32'h194000);
        chk("t6_done",   32'(first_done(12)), 32'd9);

        // length saturates at DEPTH: 16 nops
        for (int a = 0; a < 16; a++) prog(a, 23'h000000);
        prog_len = 5'd31;
        run(36, -1, -1, -1);
        chk("t7_done",   32'(first_done(36)), 32'd17);
        chk("t7_pc16",   32'(pc_log[16]), 32'hf);
        chk("t7_nvld",   32'(vld_count(36)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
